// File: rtl/conv_param.sv
// conv_param: parametrised 1-D sliding-window convolution engine.
// Loads x[M] and f[N] concurrently, streams y[i] = sum_j x[i+j]*f[j] in order.
module conv_param #(
    parameter int M     = 12,
    parameter int N     = 5,
    parameter int T     = 10,
    parameter int OUT_W = 2*T+$clog2(N),
    parameter int RELU  = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [T-1:0]     x_data,
    input  logic                    x_valid,
    output logic                    x_ready,
    input  logic signed [T-1:0]     f_data,
    input  logic                    f_valid,
    output logic                    f_ready,
    output logic signed [OUT_W-1:0] y_data,
    output logic                    y_valid,
    input  logic                    y_ready
);

    localparam int ACC_W = 2*T + $clog2(N);
    localparam int PW    = 2*T;
    localparam int XCW   = $clog2(M+1);
    localparam int FCW   = $clog2(N+1);
    localparam int XAW   = (M > 1) ? $clog2(M) : 1;
    localparam int FAW   = (N > 1) ? $clog2(N) : 1;

    localparam logic [XCW-1:0] M_C    = XCW'(M);
    localparam logic [XCW-1:0] I_LAST = XCW'(M-N);
    localparam logic [FCW-1:0] N_C    = FCW'(N);
    localparam logic [FCW-1:0] N_LAST = FCW'(N-1);

    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = ~MAXV;

    typedef enum logic [1:0] {
        LOAD    = 2'd0,
        COMPUTE = 2'd1,
        OUTPUT  = 2'd2
    } state_e;

    state_e state, state_nx;

    logic signed [T-1:0] x_mem [M];
    logic signed [T-1:0] f_mem [N];

    logic [XCW-1:0] x_cnt, x_cnt_d;
    logic [FCW-1:0] f_cnt, f_cnt_d;
    logic [XCW-1:0] i_idx;
    logic [FCW-1:0] rd_j;
    logic [FCW-1:0] acc_cnt;
    logic [XAW-1:0] x_addr;
    logic [FAW-1:0] f_addr;

    logic rd_en, rd_v, prd_v;
    logic x_fire, f_fire, y_fire;
    logic last_out, acc_done, start;

    logic signed [T-1:0]     x_q, f_q;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] relu_v;

    assign x_addr = XAW'(i_idx + XCW'(rd_j));
    assign f_addr = FAW'(rd_j);

    always_comb begin
        x_fire   = x_valid && x_ready;
        f_fire   = f_valid && f_ready;
        y_valid  = (state == OUTPUT);
        y_fire   = y_valid && y_ready;
        last_out = (i_idx == I_LAST);
        acc_done = prd_v && (acc_cnt == N_LAST);
        rd_en    = (state == COMPUTE) && (rd_j < N_C);
        x_cnt_d  = x_cnt;
        f_cnt_d  = f_cnt;
        state_nx = state;
        unique case (state)
            LOAD: begin
                if (x_fire) x_cnt_d = x_cnt + XCW'(1);
                if (f_fire) f_cnt_d = f_cnt + FCW'(1);
                if (x_cnt_d == M_C && f_cnt_d == N_C)
                    state_nx = COMPUTE;
            end
            COMPUTE: begin
                if (acc_done) state_nx = OUTPUT;
            end
            OUTPUT: begin
                if (y_fire) begin
                    if (last_out) begin
                        state_nx = LOAD;
                        x_cnt_d  = '0;
                        f_cnt_d  = '0;
                    end else begin
                        state_nx = COMPUTE;
                    end
                end
            end
            default: state_nx = LOAD;
        endcase
        start = (state_nx == COMPUTE) && (state != COMPUTE);
    end

    always_ff @(posedge clk) begin
        if (reset) state <= LOAD;
        else       state <= state_nx;
    end

    // Readies are registered so they never depend on the same-cycle valids.
    always_ff @(posedge clk) begin
        if (reset) begin
            x_cnt   <= '0;
            f_cnt   <= '0;
            x_ready <= 1'b0;
            f_ready <= 1'b0;
            i_idx   <= '0;
            rd_j    <= '0;
            acc_cnt <= '0;
            rd_v    <= 1'b0;
            prd_v   <= 1'b0;
            acc     <= '0;
        end else begin
            x_cnt   <= x_cnt_d;
            f_cnt   <= f_cnt_d;
            x_ready <= (state_nx == LOAD) && (x_cnt_d < M_C);
            f_ready <= (state_nx == LOAD) && (f_cnt_d < N_C);
            if (y_fire)
                i_idx <= last_out ? '0 : i_idx + XCW'(1);
            if (start) begin
                rd_j    <= '0;
                acc_cnt <= '0;
                acc     <= '0;
                rd_v    <= 1'b0;
                prd_v   <= 1'b0;
            end else begin
                rd_v  <= rd_en;
                prd_v <= rd_v;
                if (rd_en)
                    rd_j <= rd_j + FCW'(1);
                if (prd_v) begin
                    acc     <= acc + ACC_W'(prod);
                    acc_cnt <= acc_cnt + FCW'(1);
                end
            end
        end
    end

    // Read -> multiply -> accumulate, one tap per cycle.
    always_ff @(posedge clk) begin
        if (x_fire) x_mem[XAW'(x_cnt)] <= x_data;
        if (f_fire) f_mem[FAW'(f_cnt)] <= f_data;
        if (rd_en) begin
            x_q <= x_mem[x_addr];
            f_q <= f_mem[f_addr];
        end
        prod <= PW'(x_q) * PW'(f_q);
    end

    always_comb begin
        relu_v = acc;
        if (RELU != 0 && acc[ACC_W-1])
            relu_v = '0;
        if (relu_v > MAXV)
            y_data = OUT_W'(MAXV);
        else if (relu_v < MINV)
            y_data = OUT_W'(MINV);
        else
            y_data = OUT_W'(relu_v);
    end

endmodule

// File: tb/tb_conv_param.sv
// tb_conv_param: randomized valid/ready stimulus on four conv_param configs,
// results checked against a sliding-window sum model kept in the bench.
module tb_conv_param;

    logic clk = 1'b0;
    logic reset;
    logic signed [9:0] x_data, f_data;
    logic x_valid, f_valid, y_ready;
    logic [1:0] sel;
    logic [3:0] xr, fr, yv;
    logic signed [22:0] yd0;
    logic signed [15:0] yd1, yd2;
    logic signed [21:0] yd3;
    logic x_ready_m, f_ready_m, yv_m;
    logic signed [31:0] yd_m;

    int n_tests = 0;
    int n_fail  = 0;
    int xq[$];
    int fq[$];
    longint got[$];
    longint exp_q[$];
    longint stall_d[$];
    bit stall_v[$];
    bit tmo, snap_fr, snap_xr, post_xr, post_fr, post_yv;

    always #5 clk = ~clk;

    conv_param u_def (
        .clk(clk), .reset(reset),
        .x_data(x_data), .x_valid(x_valid && sel == 2'd0), .x_ready(xr[0]),
        .f_data(f_data), .f_valid(f_valid && sel == 2'd0), .f_ready(fr[0]),
        .y_data(yd0), .y_valid(yv[0]), .y_ready(y_ready && sel == 2'd0)
    );

    conv_param #(.OUT_W(16)) u_sat (
        .clk(clk), .reset(reset),
        .x_data(x_data), .x_valid(x_valid && sel == 2'd1), .x_ready(xr[1]),
        .f_data(f_data), .f_valid(f_valid && sel == 2'd1), .f_ready(fr[1]),
        .y_data(yd1), .y_valid(yv[1]), .y_ready(y_ready && sel == 2'd1)
    );

    conv_param #(.OUT_W(16), .RELU(1)) u_relu (
        .clk(clk), .reset(reset),
        .x_data(x_data), .x_valid(x_valid && sel == 2'd2), .x_ready(xr[2]),
        .f_data(f_data), .f_valid(f_valid && sel == 2'd2), .f_ready(fr[2]),
        .y_data(yd2), .y_valid(yv[2]), .y_ready(y_ready && sel == 2'd2)
    );

    conv_param #(.M(4), .N(4)) u_sq (
        .clk(clk), .reset(reset),
        .x_data(x_data), .x_valid(x_valid && sel == 2'd3), .x_ready(xr[3]),
        .f_data(f_data), .f_valid(f_valid && sel == 2'd3), .f_ready(fr[3]),
        .y_data(yd3), .y_valid(yv[3]), .y_ready(y_ready && sel == 2'd3)
    );

    always_comb begin
        x_ready_m = xr[sel];
        f_ready_m = fr[sel];
        yv_m      = yv[sel];
        case (sel)
            2'd0:    yd_m = 32'(yd0);
            2'd1:    yd_m = 32'(yd1);
            2'd2:    yd_m = 32'(yd2);
            default: yd_m = 32'(yd3);
        endcase
    end

    // Expected outputs straight from the definition: windowed dot product,
    // optional clamp at zero, then clamp to the output range.
    task automatic build_exp();
        int n, ow;
        bit relu;
        longint s, hi, lo;
        n    = (sel == 2'd3) ? 4 : 5;
        ow   = (sel == 2'd0) ? 23 : (sel == 2'd3) ? 22 : 16;
        relu = (sel == 2'd2);
        hi   = (longint'(1) << (ow - 1)) - 1;
        lo   = -(longint'(1) << (ow - 1));
        exp_q.delete();
        for (int i = 0; i + n <= xq.size(); i++) begin
            s = 0;
            for (int j = 0; j < n; j++)
                s += longint'(xq[i+j]) * longint'(fq[j]);
            if (relu && s < 0) s = 0;
            if (s > hi) s = hi;
            if (s < lo) s = lo;
            exp_q.push_back(s);
        end
    endtask

    task automatic run_job(input int xp, input int fp, input int yp,
                           input bit f_first, input int stall_at,
                           input int stop_at);
        int xi, fi, k, cyc, hold, snap_at;
        xi = 0; fi = 0; k = 0; cyc = 0; hold = 0; snap_at = -1;
        got.delete();
        stall_v.delete();
        stall_d.delete();
        tmo = 1'b0;
        while (k < stop_at) begin
            @(negedge clk);
            cyc++;
            if (cyc > 3000) begin
                tmo = 1'b1;
                break;
            end
            if (cyc == snap_at) begin
                snap_fr = f_ready_m;
                snap_xr = x_ready_m;
            end
            f_valid = 1'b0;
            x_valid = 1'b0;
            if (fi < fq.size() && $urandom_range(99) < fp) begin
                f_valid = 1'b1;
                f_data  = 10'(fq[fi]);
            end
            if (xi < xq.size() && !(f_first && fi < fq.size())
                && $urandom_range(99) < xp) begin
                x_valid = 1'b1;
                x_data  = 10'(xq[xi]);
            end
            if (f_valid && f_ready_m) begin
                fi++;
                if (fi == fq.size()) snap_at = cyc + 1;
            end
            if (x_valid && x_ready_m) xi++;
            if (hold == 0 && k == stall_at && yv_m && stall_v.size() == 0)
                hold = 10;
            if (hold > 0) begin
                y_ready = 1'b0;
                hold--;
                stall_v.push_back(yv_m);
                stall_d.push_back(longint'(yd_m));
            end else begin
                y_ready = ($urandom_range(99) < yp);
            end
            if (yv_m && y_ready) begin
                got.push_back(longint'(yd_m));
                k++;
            end
        end
        @(negedge clk);
        post_xr = x_ready_m;
        post_fr = f_ready_m;
        post_yv = yv_m;
        x_valid = 1'b0;
        f_valid = 1'b0;
        y_ready = 1'b0;
    endtask

    task automatic load_ramp(input int x0);
        xq.delete();
        fq.delete();
        for (int i = 0; i < 12; i++) xq.push_back(x0 + i);
        for (int i = 1; i <= 5; i++) fq.push_back(i);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_tests++;
        if (xr !== 4'd0 || fr !== 4'd0 || yv !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl xr=%b fr=%b yv=%b want 0000", xr, fr, yv);
        end
        n_tests++;
        if (yd0 !== '0 || yd1 !== '0 || yd2 !== '0 || yd3 !== '0) begin
            n_fail++;
            $display("FAIL reset_ydata got %0d %0d %0d %0d want 0", yd0, yd1, yd2, yd3);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (xr !== 4'hf || fr !== 4'hf) begin
            n_fail++;
            $display("FAIL ready_rise xr=%b fr=%b want 1111", xr, fr);
        end
    endtask

    task automatic test_basic();
        sel = 2'd0;
        load_ramp(1);
        build_exp();
        run_job(100, 100, 100, 1'b0, -1, 8);
        n_tests++;
        if (tmo || got.size() != 8) begin
            n_fail++;
            $display("FAIL basic_count got=%0d want=8 tmo=%0d", got.size(), tmo);
        end
        foreach (exp_q[i]) begin
            n_tests++;
            if (i >= got.size() || got[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_y[%0d] got=%0d want=%0d", i,
                         (i < got.size()) ? got[i] : 0, exp_q[i]);
            end
        end
        n_tests++;
        if (!post_xr || !post_fr || post_yv) begin
            n_fail++;
            $display("FAIL basic_after xr=%0d fr=%0d yv=%0d want 1 1 0",
                     post_xr, post_fr, post_yv);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] s_sel [3] = '{2'd1, 2'd1, 2'd2};
        int s_x [3] = '{511, -512, -512};
        for (int c = 0; c < 3; c++) begin
            sel = s_sel[c];
            xq.delete();
            fq.delete();
            for (int i = 0; i < 12; i++) xq.push_back(s_x[c]);
            for (int i = 0; i < 5; i++) fq.push_back(511);
            build_exp();
            run_job(100, 100, 100, 1'b0, -1, 8);
            n_tests++;
            if (tmo || got.size() != 8) begin
                n_fail++;
                $display("FAIL sat%0d_count got=%0d want=8", c, got.size());
            end
            foreach (exp_q[i]) begin
                n_tests++;
                if (i >= got.size() || got[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL sat%0d_y[%0d] got=%0d want=%0d", c, i,
                             (i < got.size()) ? got[i] : 0, exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_stall();
        int bad;
        sel = 2'd0;
        load_ramp(1);
        build_exp();
        run_job(100, 100, 100, 1'b0, 3, 8);
        bad = 0;
        foreach (stall_v[i])
            if (stall_v[i] !== 1'b1 || stall_d[i] !== exp_q[3]) bad++;
        n_tests++;
        if (stall_v.size() != 10 || bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold samples=%0d bad=%0d want 10 0 (y=%0d)",
                     stall_v.size(), bad, exp_q[3]);
        end
        n_tests++;
        if (tmo || got != exp_q) begin
            n_fail++;
            $display("FAIL stall_seq got=%p want=%p", got, exp_q);
        end
    endtask

    task automatic test_interleave();
        sel = 2'd0;
        load_ramp(1);
        build_exp();
        run_job(50, 100, 100, 1'b1, -1, 8);
        n_tests++;
        if (snap_fr !== 1'b0 || snap_xr !== 1'b1) begin
            n_fail++;
            $display("FAIL ffirst_ready fr=%0d xr=%0d want 0 1", snap_fr, snap_xr);
        end
        n_tests++;
        if (tmo || got != exp_q) begin
            n_fail++;
            $display("FAIL ffirst_seq got=%p want=%p", got, exp_q);
        end
        run_job(100, 100, 100, 1'b0, -1, 8);
        n_tests++;
        if (tmo || got != exp_q) begin
            n_fail++;
            $display("FAIL simul_seq got=%p want=%p", got, exp_q);
        end
    endtask

    task automatic test_reset_mid();
        int bad;
        sel = 2'd0;
        load_ramp(1);
        run_job(100, 100, 100, 1'b0, -1, 2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (yv_m !== 1'b0) bad++;
        end
        n_tests++;
        if (bad != 0 || x_ready_m !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_idle yv_cycles=%0d xr=%0d want 0 1", bad, x_ready_m);
        end
        load_ramp(2);
        build_exp();
        run_job(100, 100, 100, 1'b0, -1, 8);
        n_tests++;
        if (tmo || got != exp_q) begin
            n_fail++;
            $display("FAIL rstmid_seq got=%p want=%p", got, exp_q);
        end
    endtask

    task automatic test_back_to_back();
        int x_a [4] = '{1, 2, 3, 4};
        sel = 2'd3;
        for (int r = 0; r < 2; r++) begin
            xq.delete();
            fq.delete();
            for (int i = 0; i < 4; i++) xq.push_back((r == 0) ? x_a[i] : x_a[3-i]);
            fq.push_back(1); fq.push_back(0); fq.push_back(0); fq.push_back(-1);
            build_exp();
            run_job(100, 100, 100, 1'b0, -1, 1);
            n_tests++;
            if (tmo || got != exp_q) begin
                n_fail++;
                $display("FAIL b2b%0d_y got=%p want=%p", r, got, exp_q);
            end
            n_tests++;
            if (!post_xr || !post_fr || post_yv) begin
                n_fail++;
                $display("FAIL b2b%0d_ready xr=%0d fr=%0d yv=%0d want 1 1 0",
                         r, post_xr, post_fr, post_yv);
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            sel = 2'(r % 3);
            xq.delete();
            fq.delete();
            for (int i = 0; i < 12; i++) xq.push_back(int'($urandom_range(1023)) - 512);
            for (int i = 0; i < 5; i++) fq.push_back(int'($urandom_range(1023)) - 512);
            build_exp();
            run_job(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                    int'($urandom_range(100, 30)), 1'($urandom_range(1)), -1, 8);
            n_tests++;
            if (tmo || got != exp_q) begin
                n_fail++;
                $display("FAIL rand%0d_seq sel=%0d got=%p want=%p", r, sel, got, exp_q);
            end
        end
    endtask

    initial begin
        reset   = 1'b1;
        x_valid = 1'b0;
        f_valid = 1'b0;
        y_ready = 1'b0;
        x_data  = '0;
        f_data  = '0;
        sel     = 2'd0;
        test_reset();
        test_basic();
        test_saturation();
        test_stall();
        test_interleave();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
